// File: rtl/ram_dma_if.sv
// Command and RAM-port bundle between the system controller, ram_dma and the 32K x 8 RAM.
// master: the DMA engine; slave: the controller/RAM side that drives commands and read data.
interface ram_dma_if #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [ADDR_W-1:0] src_i;
  logic [ADDR_W-1:0] dst_i;
  logic [LEN_W-1:0]  len_i;
  logic [7:0]        fill_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_din_o;
  logic [7:0]        ram_dout_i;

  modport master (
    input  start_i, op_i, src_i, dst_i, len_i, fill_i, ram_dout_i,
    output busy_o, done_o, err_o, err_addr_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_din_o
  );

  modport slave (
    output start_i, op_i, src_i, dst_i, len_i, fill_i, ram_dout_i,
    input  busy_o, done_o, err_o, err_addr_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_din_o
  );
endinterface

// File: rtl/ram_dma.sv
// Block fill / copy / verify engine mastering the RAM_32K8 port; RAM read data lags the request by one clock.
//
// state    | meaning
// IDLE     | waiting for start_i
// FILL     | writing fill value, one byte per cycle
// COPY_RD  | reading source byte
// COPY_WR  | writing that byte (din taken straight from ram_dout_i)
// VER      | issuing reads and comparing the previous read's data
// VER_TAIL | comparing the last read's data, no access
// DONE     | one-cycle completion pulse
module ram_dma #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  ram_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FILL, COPY_RD, COPY_WR, VER, VER_TAIL, DONE
  } state_t;

  state_t            r_state, w_nxt_state;
  logic [ADDR_W-1:0] r_ptr_a, w_nxt_ptr_a;
  logic [ADDR_W-1:0] r_ptr_b, w_nxt_ptr_b;
  logic [LEN_W-1:0]  r_cnt, w_nxt_cnt;
  logic [7:0]        r_fill, w_nxt_fill;
  logic              r_en, w_nxt_en;
  logic              r_we, w_nxt_we;
  logic [ADDR_W-1:0] r_addr, w_nxt_addr;
  logic [7:0]        r_din, w_nxt_din;
  logic              r_busy, w_nxt_busy;
  logic              r_done, w_nxt_done;
  logic              r_err, w_nxt_err;
  logic [ADDR_W-1:0] r_err_addr, w_nxt_err_addr;
  logic              r_chk;
  logic [ADDR_W-1:0] r_caddr;
  logic              w_mismatch;

  // r_chk/r_caddr describe the verify read whose data is on ram_dout_i this cycle
  assign w_mismatch = r_chk && (bus.ram_dout_i != r_fill);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_ptr_a    = r_ptr_a;
    w_nxt_ptr_b    = r_ptr_b;
    w_nxt_cnt      = r_cnt;
    w_nxt_fill     = r_fill;
    w_nxt_en       = 1'b0;
    w_nxt_we       = 1'b0;
    w_nxt_addr     = '0;
    w_nxt_din      = 8'h00;
    w_nxt_busy     = 1'b0;
    w_nxt_done     = 1'b0;
    w_nxt_err      = r_err;
    w_nxt_err_addr = r_err_addr;
    unique case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_nxt_fill     = bus.fill_i;
          w_nxt_err      = 1'b0;
          w_nxt_err_addr = '0;
          if (bus.len_i == '0) begin
            w_nxt_state = DONE;
            w_nxt_done  = 1'b1;
          end else begin
            unique case (bus.op_i)
              2'b00: begin
                w_nxt_state = FILL;
                w_nxt_busy  = 1'b1;
                w_nxt_en    = 1'b1;
                w_nxt_we    = 1'b1;
                w_nxt_addr  = bus.dst_i;
                w_nxt_din   = bus.fill_i;
                w_nxt_ptr_b = bus.dst_i + ADDR_W'(1);
                w_nxt_cnt   = bus.len_i - LEN_W'(1);
              end
              2'b01: begin
                w_nxt_state = COPY_RD;
                w_nxt_busy  = 1'b1;
                w_nxt_en    = 1'b1;
                w_nxt_addr  = bus.src_i;
                w_nxt_ptr_a = bus.src_i + ADDR_W'(1);
                w_nxt_ptr_b = bus.dst_i;
                w_nxt_cnt   = bus.len_i;
              end
              2'b10: begin
                w_nxt_state = VER;
                w_nxt_busy  = 1'b1;
                w_nxt_en    = 1'b1;
                w_nxt_addr  = bus.src_i;
                w_nxt_ptr_a = bus.src_i + ADDR_W'(1);
                w_nxt_cnt   = bus.len_i - LEN_W'(1);
              end
              default: begin
                w_nxt_state = DONE;
                w_nxt_done  = 1'b1;
              end
            endcase
          end
        end
      end
      FILL: begin
        if (r_cnt == '0) begin
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_busy  = 1'b1;
          w_nxt_en    = 1'b1;
          w_nxt_we    = 1'b1;
          w_nxt_addr  = r_ptr_b;
          w_nxt_din   = r_fill;
          w_nxt_ptr_b = r_ptr_b + ADDR_W'(1);
          w_nxt_cnt   = r_cnt - LEN_W'(1);
        end
      end
      COPY_RD: begin
        w_nxt_state = COPY_WR;
        w_nxt_busy  = 1'b1;
        w_nxt_en    = 1'b1;
        w_nxt_we    = 1'b1;
        w_nxt_addr  = r_ptr_b;
        w_nxt_ptr_b = r_ptr_b + ADDR_W'(1);
        w_nxt_cnt   = r_cnt - LEN_W'(1);
      end
      COPY_WR: begin
        if (r_cnt == '0) begin
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_state = COPY_RD;
          w_nxt_busy  = 1'b1;
          w_nxt_en    = 1'b1;
          w_nxt_addr  = r_ptr_a;
          w_nxt_ptr_a = r_ptr_a + ADDR_W'(1);
        end
      end
      VER: begin
        if (w_mismatch) begin
          w_nxt_state    = DONE;
          w_nxt_done     = 1'b1;
          w_nxt_err      = 1'b1;
          w_nxt_err_addr = r_caddr;
        end else if (r_cnt == '0) begin
          w_nxt_state = VER_TAIL;
          w_nxt_busy  = 1'b1;
        end else begin
          w_nxt_busy  = 1'b1;
          w_nxt_en    = 1'b1;
          w_nxt_addr  = r_ptr_a;
          w_nxt_ptr_a = r_ptr_a + ADDR_W'(1);
          w_nxt_cnt   = r_cnt - LEN_W'(1);
        end
      end
      VER_TAIL: begin
        w_nxt_state = DONE;
        w_nxt_done  = 1'b1;
        if (w_mismatch) begin
          w_nxt_err      = 1'b1;
          w_nxt_err_addr = r_caddr;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ptr_a    <= '0;
      r_ptr_b    <= '0;
      r_cnt      <= '0;
      r_fill     <= 8'h00;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_chk      <= 1'b0;
      r_caddr    <= '0;
    end else begin
      r_ptr_a    <= w_nxt_ptr_a;
      r_ptr_b    <= w_nxt_ptr_b;
      r_cnt      <= w_nxt_cnt;
      r_fill     <= w_nxt_fill;
      r_en       <= w_nxt_en;
      r_we       <= w_nxt_we;
      r_addr     <= w_nxt_addr;
      r_din      <= w_nxt_din;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_err      <= w_nxt_err;
      r_err_addr <= w_nxt_err_addr;
      r_chk      <= (r_state == VER) && r_en;
      r_caddr    <= r_addr;
    end
  end

  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.err_o      = r_err;
  assign bus.err_addr_o = r_err_addr;
  assign bus.ram_en_o   = r_en;
  assign bus.ram_we_o   = r_we;
  assign bus.ram_addr_o = r_addr;
  // copy writes forward the byte read in the previous cycle without a register stage
  assign bus.ram_din_o  = (r_state == COPY_WR) ? bus.ram_dout_i : r_din;

endmodule

// File: tb/tb_ram_dma.sv
// Scoreboard bench for ram_dma: a behavioural RAM plus a shadow-memory model that predicts every access and completion.
module tb_ram_dma;
  localparam int AW = 15;
  localparam int LW = 16;

  typedef struct {
    int         cyc;
    logic       we;
    logic [14:0] addr;
    logic [7:0] din;
  } acc_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [14:0] eaddr;
  } dn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_dma_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
  ram_dma #(.ADDR_W(AW), .LEN_W(LW)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  logic [7:0] mem [0:32767];
  logic [7:0] mdl [0:32767];
  acc_t aq[$];
  dn_t  dq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   sb_on = 1'b0;
  int   busy_lo = 0;
  int   busy_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RAM: synchronous write, read data one clock after the request
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_din_o;
      else              bus.ram_dout_i <= mem[bus.ram_addr_o];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_err_addr"}, bus.err_addr_o, 0);
    chk({tag, "_en"}, bus.ram_en_o, 0);
    chk({tag, "_we"}, bus.ram_we_o, 0);
    chk({tag, "_addr"}, bus.ram_addr_o, 0);
    chk({tag, "_din"}, bus.ram_din_o, 0);
  endtask

  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      chk("busy", bus.busy_o, (cyc >= busy_lo && cyc < busy_hi) ? 1 : 0);
      if (bus.ram_en_o) begin
        if (aq.size() == 0) chk("unexpected_access", bus.ram_addr_o, -1);
        else begin
          acc_t a;
          a = aq.pop_front();
          chk("acc_cycle", cyc, a.cyc);
          chk("acc_we", bus.ram_we_o, a.we);
          chk("acc_addr", bus.ram_addr_o, a.addr);
          if (a.we) chk("acc_din", bus.ram_din_o, a.din);
        end
      end else begin
        chk("idle_we_din", {bus.ram_we_o, bus.ram_din_o}, 0);
      end
      if (bus.done_o) begin
        done_cnt++;
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_err", bus.err_o, d.err);
          if (d.err) chk("done_err_addr", bus.err_addr_o, d.eaddr);
        end
      end
    end
  end

  task automatic push_acc(input int c, input logic we, input logic [14:0] a, input logic [7:0] d);
    acc_t e;
    e.cyc = c; e.we = we; e.addr = a; e.din = d;
    aq.push_back(e);
  endtask

  // issue one command, predict its accesses and completion from the shadow memory, wait for done
  task automatic run_op(input logic [1:0] op, input logic [14:0] src, input logic [14:0] dst,
                        input logic [15:0] len, input logic [7:0] fill, input bit hold);
    int ct, dk, dc0, n, first;
    logic [14:0] a;
    logic [7:0] v;
    dn_t d;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.src_i = src; bus.dst_i = dst;
    bus.len_i = len; bus.fill_i = fill;
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    ct = cyc;
    if (!hold) bus.start_i = 1'b0;
    d.err = 1'b0; d.eaddr = '0;
    if (len == 0 || op == 2'b11) dk = 1;
    else if (op == 2'b00) begin
      for (int i = 0; i < int'(len); i++) begin
        a = dst + 15'(i);
        push_acc(ct + i, 1'b1, a, fill);
        mdl[a] = fill;
      end
      dk = int'(len) + 1;
    end else if (op == 2'b01) begin
      for (int i = 0; i < int'(len); i++) begin
        a = src + 15'(i);
        v = mdl[a];
        push_acc(ct + 2*i, 1'b0, a, 8'h00);
        a = dst + 15'(i);
        push_acc(ct + 2*i + 1, 1'b1, a, v);
        mdl[a] = v;
      end
      dk = 2*int'(len) + 1;
    end else begin
      first = -1;
      for (int i = 0; i < int'(len) && first < 0; i++)
        if (mdl[src + 15'(i)] != fill) first = i;
      if (first < 0) begin
        for (int i = 0; i < int'(len); i++) push_acc(ct + i, 1'b0, src + 15'(i), 8'h00);
        dk = int'(len) + 2;
      end else begin
        for (int i = 0; i < int'(len) && i <= first + 1; i++)
          push_acc(ct + i, 1'b0, src + 15'(i), 8'h00);
        dk = first + 3;
        d.err = 1'b1;
        d.eaddr = src + 15'(first);
      end
    end
    d.cyc = ct + dk - 1;
    dq.push_back(d);
    busy_lo = ct;
    busy_hi = ct + dk - 1;
    for (n = 0; n < dk + 10 && done_cnt == dc0; n++) @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    if (done_cnt == dc0) begin
      chk("done_timeout", 0, 1);
      aq.delete();
      dq.delete();
    end
    chk("acc_leftover", aq.size(), 0);
  endtask

  initial begin
    int bad;
    logic [14:0] s, t;
    logic [15:0] l;
    logic [7:0] f;
    logic [1:0] op;
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.src_i = '0; bus.dst_i = '0;
    bus.len_i = '0; bus.fill_i = 8'h00; bus.ram_dout_i = 8'h00;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'($urandom);
      mdl[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // reset in the middle of a long fill
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.dst_i = 15'h4000; bus.len_i = 16'd100; bus.fill_i = 8'hEE;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk_zero("reset_mid");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_no_done", bus.done_o, 0);
      chk("reset_no_en", bus.ram_en_o, 0);
    end
    for (int i = 0; i < 100; i++) begin
      mem[15'h4000 + 15'(i)] = 8'h00;
      mdl[15'h4000 + 15'(i)] = 8'h00;
    end
    sb_on = 1'b1;

    run_op(2'b00, 15'h0000, 15'h7FFE, 16'd4, 8'hA5, 1'b0);
    chk("fill_7ffe", mem[15'h7FFE], 8'hA5);
    chk("fill_7fff", mem[15'h7FFF], 8'hA5);
    chk("fill_0000", mem[15'h0000], 8'hA5);
    chk("fill_0001", mem[15'h0001], 8'hA5);

    mem[15'h100] = 8'h11; mem[15'h101] = 8'h22; mem[15'h102] = 8'h33; mem[15'h103] = 8'h44;
    mdl[15'h100] = 8'h11; mdl[15'h101] = 8'h22; mdl[15'h102] = 8'h33; mdl[15'h103] = 8'h44;
    run_op(2'b01, 15'h0100, 15'h0200, 16'd4, 8'h00, 1'b0);
    chk("copy_200", mem[15'h200], 8'h11);
    chk("copy_201", mem[15'h201], 8'h22);
    chk("copy_202", mem[15'h202], 8'h33);
    chk("copy_203", mem[15'h203], 8'h44);
    run_op(2'b01, 15'h0100, 15'h0101, 16'd3, 8'h00, 1'b0);
    chk("overlap_101", mem[15'h101], 8'h11);
    chk("overlap_102", mem[15'h102], 8'h11);
    chk("overlap_103", mem[15'h103], 8'h11);

    run_op(2'b00, 15'h0000, 15'h0000, 16'd1024, 8'h5A, 1'b0);
    run_op(2'b10, 15'h0000, 15'h0000, 16'd1024, 8'h5A, 1'b0);
    mem[15'h123] = 8'h5B;
    mdl[15'h123] = 8'h5B;
    run_op(2'b10, 15'h0000, 15'h0000, 16'd1024, 8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", bus.err_o, 1);
    chk("err_addr_sticky", bus.err_addr_o, 15'h123);

    run_op(2'b00, 15'h0000, 15'h0500, 16'd0, 8'h77, 1'b0);
    run_op(2'b11, 15'h0600, 15'h0700, 16'd5, 8'h77, 1'b0);
    run_op(2'b00, 15'h0000, 15'h0800, 16'd3, 8'h99, 1'b1);
    repeat (6) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 3) == 0) ? 15'h7FF0 + 15'($urandom_range(0, 15)) : 15'($urandom);
      t  = 15'($urandom);
      l  = 16'($urandom_range(0, 40));
      f  = 8'($urandom);
      if (op == 2'b10 && $urandom_range(0, 1) == 1) run_op(2'b00, 15'h0000, s, l, f, 1'b0);
      run_op(op, s, t, l, f, 1'b0);
    end

    run_op(2'b00, 15'h0000, 15'h2345, 16'd32768, 8'h3C, 1'b0);
    bad = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] != 8'h3C) bad++;
    chk("full_fill_scan", bad, 0);
    chk("queues_empty", aq.size() + dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
